spi_master_mcp23s17: RTL and testbench
======================================

// Module: spi_master_mcp23s17
// PURPOSE
// - Upstream SPI master that drives the MCP23S17-style SPI slave.
// - It sends one 3-byte frame per request: opcode, register address, then data.
// - It also captures the MISO byte returned during the third byte and presents it as rdData.
// - It runs entirely in the sysClk domain and generates spiClk, cs and mosi by clock division.
// PARAMETERS
// - CLK_DIV   8  sysClk cycles per spiClk half-period.
//   - Legal range 4..255; the minimum of 4 covers the slave's input synchroniser latency.
// - CS_SETUP  4  sysClk cycles from cs falling to the start of the first spiClk low phase. Legal 1..255.
// - CS_HOLD   4  sysClk cycles from the last spiClk fall to cs rising. Legal 1..255.
// PORTS
// - sysClk   in   1  system clock
// - reset    in   1  synchronous, active-high reset
// - start    in   1  request pulse; accepted only while ready=1
// - hwAddr   in   3  device hardware address (A2..A0)
// - rw       in   1  1=read, 0=write
// - regAddr  in   8  register address (byte 2)
// - wrData   in   8  write data (byte 3); byte 3 is sent as 0x00 when rw=1
// - ready    out  1  idle, able to accept start
// - done     out  1  one-cycle pulse at end of frame
// - rdData   out  8  MISO byte captured during byte 3; held until the next done
// - spiClk   out  1  SPI clock, idle low
// - cs       out  1  chip select, active low
// - mosi     out  1  serial data to slave, MSB first
// - miso     in   1  serial data from slave
// BEHAVIOUR
// - Reset values: ready=1, done=0, rdData=0x00, spiClk=0, cs=1, mosi=0. FSM goes to IDLE; all counters clear.
// - Reset mid-frame aborts at the next edge and drives the same values; no done pulse is produced.
// - Opcode = {4'b0100, hwAddr, rw}. Example: hwAddr=0, rw=1 gives 0x41.
// - States and transitions:
//   - IDLE: ready=1. start=1 latches all inputs, loads the tx shift register with the opcode, drives cs=0 next cycle, then goes to SETUP.
//   - SETUP: hold for CS_SETUP cycles, then go to LOW.
//   - LOW: spiClk=0 for CLK_DIV cycles, then drive spiClk=1 and go to HIGH.
//   - HIGH: spiClk=1 for CLK_DIV cycles. On the last cycle:
//     - sample miso (synchronised) into the rx shift register and shift tx left;
//     - drive spiClk=0;
//     - at bit 7 of byte 0 or 1, reload tx with the next byte.
//     - If bit 23 is done go to HOLD, else go to LOW.
//   - HOLD: spiClk=0 for CS_HOLD cycles, then in one cycle: cs=1, done=1, rdData<=rx byte 3. Go to IDLE.
//   - ready returns 1 on the cycle after done.
// - Counters: bitCnt is 3 bits and wraps 7->0 per byte. byteCnt is 2 bits, range 0..2. Divider counter is 8 bits.
// - mosi = tx[7] while cs=0 and 0 otherwise. It changes only on the cycle spiClk falls, or at cs fall for bit 0.
// - spiClk is exactly 24 rising edges per frame. spiClk is never high while cs=1.
// - Latency: cs is low for CS_SETUP + 48*CLK_DIV + CS_HOLD cycles, which is 392 cycles at defaults.
// - start while ready=0 is ignored: no queuing, and the latched fields are unchanged.
// - start in the same cycle as reset is ignored.
// - Inputs other than start are don't-care outside the accept cycle.
// CONFIGURATION
// - SPI_MASTER_MISO_SYNC_EN defined: miso passes through a 2-FF synchroniser before sampling.
//   - This adds 2 cycles of input delay; it is still sampled at the end of HIGH.
// - Not defined: miso is sampled directly from the port, for use when the slave shares sysClk with a registered miso.
// - Frame timing on spiClk, cs and mosi is identical in both builds.
// TESTING
// - Reset, then idle 20 cycles -> ready=1, cs=1, spiClk=0, mosi=0, done never asserted.
// - Write hwAddr=0, rw=0, regAddr=0x0A, wrData=0x55 -> mosi bytes 0x40,0x0A,0x55; 24 rises; cs low 392 cycles; one done pulse.
// - Read hwAddr=0, rw=1, regAddr=0x0A against the SPISlave model -> mosi 0x41,0x0A,0x00; rdData=0x28 at done.
// - Read regAddr=0x0F against the same model -> rdData=0xF9. rdData is held stable until the next done.
// - Assert start again at cycle 100 of a frame -> ignored; frame bytes unchanged; exactly one done; ready=0 throughout.
// - Assert reset at bit 10 of a frame -> next cycle cs=1, spiClk=0, ready=1, done=0. A new start then gives a clean 24-bit frame.

Source files
------------

// File: rtl/spi_master_mcp23s17_if.sv
// Request/response and SPI pin bundle for spi_master_mcp23s17.
// The master modport is the controller's view; the slave modport is the opposite side.
interface spi_master_mcp23s17_if;
    logic       start;
    logic [2:0] hwAddr;
    logic       rw;
    logic [7:0] regAddr;
    logic [7:0] wrData;
    logic       ready;
    logic       done;
    logic [7:0] rdData;
    logic       spiClk;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, hwAddr, rw, regAddr, wrData, miso,
        output ready, done, rdData, spiClk, cs, mosi
    );

    modport slave (
        output start, hwAddr, rw, regAddr, wrData, miso,
        input  ready, done, rdData, spiClk, cs, mosi
    );
endinterface

// File: rtl/spi_master_mcp23s17.sv
// SPI master sending one 3-byte MCP23S17 frame (opcode, register, data) per start pulse.
// Define SPI_MASTER_MISO_SYNC_EN to pass miso through a 2-FF synchroniser before sampling.
module spi_master_mcp23s17 #(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4
) (
    input  logic                  sysClk,
    input  logic                  reset,
    spi_master_mcp23s17_if.master bus
);

    typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StHold} state_e;

    localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SetupLast = 8'(CS_SETUP - 1);
    localparam logic [7:0] HoldLast  = 8'(CS_HOLD - 1);

    state_e     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] byte_q, byte_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] data_byte_q, data_byte_d;
    logic [7:0] rd_q, rd_d;
    logic       sclk_q, sclk_d;
    logic       cs_q, cs_d;
    logic       done_q, done_d;

    logic       miso_s;
    logic       ready;
    logic       accept;
    logic       div_last;
    logic       byte_end;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync_q;

    always_ff @(posedge sysClk) begin
        if (reset) begin
            miso_sync_q <= 2'b00;
        end else begin
            miso_sync_q <= {miso_sync_q[0], bus.miso};
        end
    end

    assign miso_s = miso_sync_q[1];
`else
    assign miso_s = bus.miso;
`endif

    // The cycle that carries done still reports busy, so a start there is dropped.
    assign ready    = (state_q == StIdle) && !done_q;
    assign accept   = ready && bus.start;
    assign byte_end = (bit_q == 3'd7);

    always_comb begin
        div_last = 1'b0;
        unique case (state_q)
            StSetup:       div_last = (div_q == SetupLast);
            StLow, StHigh: div_last = (div_q == DivLast);
            StHold:        div_last = (div_q == HoldLast);
            default:       div_last = 1'b0;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q     <= StIdle;
            div_q       <= 8'd0;
            bit_q       <= 3'd0;
            byte_q      <= 2'd0;
            tx_q        <= 8'd0;
            rx_q        <= 8'd0;
            reg_addr_q  <= 8'd0;
            data_byte_q <= 8'd0;
            rd_q        <= 8'd0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            reg_addr_q  <= reg_addr_d;
            data_byte_q <= data_byte_d;
            rd_q        <= rd_d;
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic and phase/bit/byte counters.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        unique case (state_q)
            StIdle: begin
                div_d  = 8'd0;
                bit_d  = 3'd0;
                byte_d = 2'd0;
                if (accept) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = StLow;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StLow: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = StHigh;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StHigh: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    bit_d   = bit_q + 3'd1;
                    state_d = StLow;
                    if (byte_end) begin
                        if (byte_q == 2'd2) begin
                            byte_d  = 2'd0;
                            state_d = StHold;
                        end else begin
                            byte_d = byte_q + 2'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StHold: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                div_d   = 8'd0;
                bit_d   = 3'd0;
                byte_d  = 2'd0;
            end
        endcase
    end

    // Output and shift-register next values; all pins come straight from flops.
    always_comb begin
        tx_d        = tx_q;
        rx_d        = rx_q;
        reg_addr_d  = reg_addr_q;
        data_byte_d = data_byte_q;
        rd_d        = rd_q;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                sclk_d = 1'b0;
                cs_d   = 1'b1;
                if (accept) begin
                    tx_d        = {4'b0100, bus.hwAddr, bus.rw};
                    reg_addr_d  = bus.regAddr;
                    data_byte_d = bus.rw ? 8'h00 : bus.wrData;
                    cs_d        = 1'b0;
                end
            end
            StSetup: begin
                sclk_d = 1'b0;
            end
            StLow: begin
                if (div_last) begin
                    sclk_d = 1'b1;
                end
            end
            StHigh: begin
                if (div_last) begin
                    sclk_d = 1'b0;
                    rx_d   = {rx_q[6:0], miso_s};
                    if (byte_end && byte_q == 2'd0) begin
                        tx_d = reg_addr_q;
                    end else if (byte_end && byte_q == 2'd1) begin
                        tx_d = data_byte_q;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
            StHold: begin
                sclk_d = 1'b0;
                if (div_last) begin
                    cs_d   = 1'b1;
                    done_d = 1'b1;
                    rd_d   = rx_q;
                end
            end
            default: begin
                sclk_d = 1'b0;
                cs_d   = 1'b1;
            end
        endcase
    end

    assign bus.ready  = ready;
    assign bus.done   = done_q;
    assign bus.rdData = rd_q;
    assign bus.spiClk = sclk_q;
    assign bus.cs     = cs_q;
    assign bus.mosi   = !cs_q && tx_q[7];

endmodule

// File: tb/tb_spi_master_mcp23s17.sv
// Directed bench for spi_master_mcp23s17 with a behavioural MCP23S17-style SPI slave.
module tb_spi_master_mcp23s17;

    logic sysClk = 1'b0;
    logic reset;
    always #5 sysClk = ~sysClk;

    spi_master_mcp23s17_if bus ();

    spi_master_mcp23s17 #(
        .CLK_DIV  (8),
        .CS_SETUP (4),
        .CS_HOLD  (4)
    ) dut (
        .sysClk (sysClk),
        .reset  (reset),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave: captures mosi on spiClk rise, returns a register byte during byte 3 of reads.
    logic [23:0] slv_bits  = 24'd0;
    int          slv_rises = 0;
    logic [7:0]  slv_data  = 8'd0;
    logic        slv_cs_last = 1'b1;

    function automatic logic [7:0] slv_reg(input logic [7:0] a);
        case (a)
            8'h0A:   return 8'h28;
            8'h0F:   return 8'hF9;
            default: return 8'h00;
        endcase
    endfunction

    always @(bus.spiClk or bus.cs) begin
        if (bus.cs === 1'b1) begin
            slv_cs_last = 1'b1;
            bus.miso    = 1'b0;
        end else if (slv_cs_last) begin
            slv_cs_last = 1'b0;
            slv_bits    = 24'd0;
            slv_rises   = 0;
        end else if (bus.spiClk === 1'b1) begin
            slv_bits = {slv_bits[22:0], bus.mosi};
            slv_rises++;
        end else begin
            if (slv_rises == 16) begin
                slv_data = slv_bits[8] ? slv_reg(slv_bits[7:0]) : 8'h00;
            end
            if (slv_rises >= 16 && slv_rises <= 23) begin
                bus.miso = slv_data[3'(23 - slv_rises)];
            end
        end
    end

    // Pin monitor, sampled at the rising edge (values of the cycle just ending).
    logic mon_en = 1'b0;
    int   done_cnt = 0;
    int   viol_cnt = 0;
    int   cs_low_run = 0;
    int   cs_low_last = 0;

    always @(posedge sysClk) begin
        if (mon_en) begin
            if (bus.done === 1'b1) done_cnt++;
            if (bus.cs === 1'b1 && (bus.spiClk !== 1'b0 || bus.mosi !== 1'b0)) viol_cnt++;
            if (bus.cs === 1'b0 && bus.ready !== 1'b0) viol_cnt++;
            if (bus.cs === 1'b0) begin
                cs_low_run++;
            end else if (cs_low_run != 0) begin
                cs_low_last = cs_low_run;
                cs_low_run  = 0;
            end
        end
    end

    task automatic run_frame(input logic [2:0] hw, input logic r, input logic [7:0] ra,
                             input logic [7:0] wd, input int poke_at, input int hold_at,
                             input logic [7:0] hold_rd, input logic [23:0] exp_bits,
                             input logic [7:0] exp_rd);
        int   d0;
        int   cycles;
        logic ok;
        d0 = done_cnt;
        ok = 1'b0;
        cycles = 0;
        @(negedge sysClk);
        bus.hwAddr = hw; bus.rw = r; bus.regAddr = ra; bus.wrData = wd; bus.start = 1'b1;
        @(negedge sysClk);
        bus.start = 1'b0;
        bus.hwAddr = ~hw; bus.rw = ~r; bus.regAddr = ~ra; bus.wrData = ~wd;
        for (int k = 1; k < 1000; k++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                cycles = k;
                break;
            end
            if (k == hold_at) check("rd_hold_mid", bus.rdData, hold_rd);
            if (k == poke_at) begin
                bus.start = 1'b1; bus.hwAddr = 3'd7; bus.regAddr = 8'hFF; bus.wrData = 8'hAA;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge sysClk);
        end
        bus.start = 1'b0;
        check("done_seen", ok, 1'b1);
        check("done_latency", cycles, 393);
        check("ready_at_done", bus.ready, 1'b0);
        check("rdData", bus.rdData, exp_rd);
        check("mosi_frame", slv_bits, exp_bits);
        check("clk_rises", slv_rises, 24);
        @(negedge sysClk);
        check("ready_after", bus.ready, 1'b1);
        check("cs_low_len", cs_low_last, 392);
        repeat (2) @(negedge sysClk);
        check("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        int k;
        reset = 1'b1;
        bus.start = 1'b0; bus.hwAddr = 3'd0; bus.rw = 1'b0; bus.regAddr = 8'd0; bus.wrData = 8'd0;
        repeat (3) @(negedge sysClk);
        reset  = 1'b0;
        mon_en = 1'b1;

        repeat (20) @(negedge sysClk);
        check("idle_ready", bus.ready, 1'b1);
        check("idle_cs", bus.cs, 1'b1);
        check("idle_sclk", bus.spiClk, 1'b0);
        check("idle_mosi", bus.mosi, 1'b0);
        check("idle_done", done_cnt, 0);
        check("idle_rd", bus.rdData, 8'h00);

        // start coinciding with reset must not launch a frame
        reset = 1'b1; bus.start = 1'b1;
        @(negedge sysClk);
        reset = 1'b0; bus.start = 1'b0;
        repeat (5) @(negedge sysClk);
        check("rst_start_cs", bus.cs, 1'b1);
        check("rst_start_ready", bus.ready, 1'b1);

        run_frame(3'd0, 1'b0, 8'h0A, 8'h55, -1, -1, 8'h00, 24'h400A55, 8'h00);
        run_frame(3'd0, 1'b1, 8'h0A, 8'h00, -1, -1, 8'h00, 24'h410A00, 8'h28);
        run_frame(3'd0, 1'b1, 8'h0F, 8'h00, -1, -1, 8'h00, 24'h410F00, 8'hF9);
        repeat (30) @(negedge sysClk);
        check("rd_hold_idle", bus.rdData, 8'hF9);
        // second start at cycle 100 ignored; rdData held mid-frame
        run_frame(3'd3, 1'b0, 8'h12, 8'hA5, 100, 200, 8'hF9, 24'h4612A5, 8'h00);

        // reset at bit 10 aborts the frame
        d0 = done_cnt;
        @(negedge sysClk);
        bus.hwAddr = 3'd0; bus.rw = 1'b0; bus.regAddr = 8'h0A; bus.wrData = 8'h55; bus.start = 1'b1;
        @(negedge sysClk);
        bus.start = 1'b0;
        k = 0;
        while (slv_rises != 10 && k < 1000) begin
            @(negedge sysClk);
            k++;
        end
        check("abort_reach_bit10", slv_rises, 10);
        reset = 1'b1;
        @(negedge sysClk);
        reset = 1'b0;
        check("abort_cs", bus.cs, 1'b1);
        check("abort_sclk", bus.spiClk, 1'b0);
        check("abort_ready", bus.ready, 1'b1);
        check("abort_done", bus.done, 1'b0);
        check("abort_mosi", bus.mosi, 1'b0);
        repeat (500) @(negedge sysClk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_cs", bus.cs, 1'b1);

        run_frame(3'd5, 1'b0, 8'h33, 8'hC3, -1, -1, 8'h00, 24'h4A33C3, 8'h00);

        check("pin_violations", viol_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
